// File: rtl/arith_check_array.sv
// arith_check_array: round-robin reference checker for arithmetic DUT results.
// Triples (a, b, dut) are dispatched across NUM_LANES reference lanes, and each
// lane recomputes the golden result over LANE_LAT cycles. Results retire in
// acceptance order with an XOR diff, a mismatch flag and saturating counters.
// Optional first-fail capture is enabled by defining ARITH_CHECK_FIRST_FAIL_EN.
module arith_check_array #(
    parameter int WIDTH     = 32,
    parameter int NUM_LANES = 4,
    parameter int LANE_LAT  = 2,
    parameter int OP        = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_dut_o,
    output logic             o_diff_valid,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_mismatch,
    output logic             o_sticky_err,
    output logic [CNT_W-1:0] o_err_cnt,
`ifdef ARITH_CHECK_FIRST_FAIL_EN
    output logic             o_ff_valid,
    output logic [WIDTH-1:0] o_ff_a,
    output logic [WIDTH-1:0] o_ff_b,
    output logic [WIDTH-1:0] o_ff_dut,
    output logic [CNT_W-1:0] o_ff_idx,
`endif
    output logic [CNT_W-1:0] o_smp_cnt
);

    localparam int CW = (LANE_LAT > 1) ? $clog2(LANE_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lane_state_t;

    lane_state_t          state_q [NUM_LANES];
    lane_state_t          state_d [NUM_LANES];
    logic [CW-1:0]        cnt_q   [NUM_LANES];
    logic [WIDTH-1:0]     a_q     [NUM_LANES];
    logic [WIDTH-1:0]     b_q     [NUM_LANES];
    logic [WIDTH-1:0]     dut_q   [NUM_LANES];
    logic [WIDTH-1:0]     ref_q   [NUM_LANES];

    logic [NUM_LANES-1:0] disp_ptr;
    logic [NUM_LANES-1:0] ret_ptr;
    logic                 ready;
    logic                 accept;
    logic                 retire;
    logic [WIDTH-1:0]     ret_diff;
    logic                 ret_mis;
`ifdef ARITH_CHECK_FIRST_FAIL_EN
    logic [WIDTH-1:0]     ret_a;
    logic [WIDTH-1:0]     ret_b;
    logic [WIDTH-1:0]     ret_dut;
`endif

    // Golden operation; every result is taken mod 2^WIDTH.
    function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (OP)
            1:       r = x - y;
            2:       r = x * y;
            default: r = x + y;
        endcase
        return r;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // One-hot pointer advance, wrapping the last lane back to lane 0.
    function automatic logic [NUM_LANES-1:0] rotate(input logic [NUM_LANES-1:0] p);
        return {p[NUM_LANES-2:0], p[NUM_LANES-1]};
    endfunction

    // Decode dispatch readiness and the retiring lane from registered state only.
    always_comb begin
        ready    = 1'b0;
        retire   = 1'b0;
        ret_diff = '0;
`ifdef ARITH_CHECK_FIRST_FAIL_EN
        ret_a    = '0;
        ret_b    = '0;
        ret_dut  = '0;
`endif
        for (int i = 0; i < NUM_LANES; i++) begin
            if (disp_ptr[i] && state_q[i] == IDLE) begin
                ready = 1'b1;
            end
            if (ret_ptr[i] && state_q[i] == DONE) begin
                retire   = 1'b1;
                ret_diff = ref_q[i] ^ dut_q[i];
`ifdef ARITH_CHECK_FIRST_FAIL_EN
                ret_a    = a_q[i];
                ret_b    = b_q[i];
                ret_dut  = dut_q[i];
`endif
            end
        end
    end

    assign accept  = i_valid && ready;
    assign ret_mis = |ret_diff;
    assign o_ready = ready;

    // Lane FSM next-state: IDLE -> BUSY on accept, BUSY -> DONE at count end,
    // DONE -> IDLE when this lane is retired.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (accept && disp_ptr[i]) state_d[i] = BUSY;
                BUSY:    if (cnt_q[i] == '0)         state_d[i] = DONE;
                DONE:    if (ret_ptr[i])             state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Lane FSM state register; reset discards any in-flight samples.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (reset) state_q[i] <= IDLE;
            else       state_q[i] <= state_d[i];
        end
    end

    // Lane datapath: latch operands on accept, then compute the reference while busy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (state_q[i] == IDLE && accept && disp_ptr[i]) begin
                a_q[i]   <= i_a;
                b_q[i]   <= i_b;
                dut_q[i] <= i_dut_o;
                cnt_q[i] <= CW'(LANE_LAT - 1);
            end else if (state_q[i] == BUSY) begin
                ref_q[i] <= golden(a_q[i], b_q[i]);
                if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
            end
        end
    end

    // Dispatch and retire pointers advance only on their own events.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_ptr <= NUM_LANES'(1);
            ret_ptr  <= NUM_LANES'(1);
        end else begin
            if (accept) disp_ptr <= rotate(disp_ptr);
            if (retire) ret_ptr  <= rotate(ret_ptr);
        end
    end

    // Retire stage: one-cycle valid pulse, diff and mismatch held until the next retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_diff_valid <= 1'b0;
            o_diff       <= '0;
            o_mismatch   <= 1'b0;
        end else begin
            o_diff_valid <= retire;
            if (retire) begin
                o_diff     <= ret_diff;
                o_mismatch <= ret_mis;
            end
        end
    end

    // Statistics: a clear takes priority over a simultaneous retire.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            o_smp_cnt    <= '0;
            o_err_cnt    <= '0;
            o_sticky_err <= 1'b0;
        end else if (retire) begin
            o_smp_cnt <= sat_inc(o_smp_cnt);
            if (ret_mis) begin
                o_err_cnt    <= sat_inc(o_err_cnt);
                o_sticky_err <= 1'b1;
            end
        end
    end

`ifdef ARITH_CHECK_FIRST_FAIL_EN
    // First-fail capture: keep the first mismatching sample and its pre-increment index.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            o_ff_valid <= 1'b0;
            o_ff_a     <= '0;
            o_ff_b     <= '0;
            o_ff_dut   <= '0;
            o_ff_idx   <= '0;
        end else if (retire && ret_mis && !o_ff_valid) begin
            o_ff_valid <= 1'b1;
            o_ff_a     <= ret_a;
            o_ff_b     <= ret_b;
            o_ff_dut   <= ret_dut;
            o_ff_idx   <= o_smp_cnt;
        end
    end
`endif

endmodule
